spi_tx_scheduler: RTL and testbench
===================================

Name: spi_tx_scheduler

Overview:
Controller that sequences the SPI output path. It decides which result byte (cost, digit or idle filler) is loaded into the byte-wide parallel-to-serial output shift register, and drives that register's load/shift enables. It frames transfers by synchronizing SCK/SS from the pads and counting shifted bits. It also tracks pending cost and digit results between the network core and the SPI master.

Parameters:
SYNC_STAGES, 2, flip-flop stages on the sck and ss_n pad inputs (2 or more)
BYTE_BITS, 8, bits per transmitted byte; bit counter width is clog2(BYTE_BITS)+1
IDLE_BYTE, 8'hFF, filler byte loaded when nothing is pending
CMD_COST, 8'h01, command code that requests a cost result

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
sck  in  1  raw SPI clock from pad, asynchronous
ss_n  in  1  raw SPI slave select from pad, active-low, asynchronous
cmd_valid  in  1  one-cycle strobe: cmd holds a received command byte
cmd  in  8  received command byte
network_done  in  1  one-cycle strobe: detected_digit is valid
detected_digit  in  4  classified digit
cost_ready  in  1  one-cycle strobe: cost_output is valid
cost_output  in  8  cost value
cost_req  out  1  one-cycle pulse requesting a cost computation
load_en  out  1  one-cycle load strobe to the output shift register
tx_byte  out  8  parallel data for the output shift register
shift_en  out  1  one-cycle pulse: shift the output register by one bit
byte_sent  out  1  one-cycle pulse after BYTE_BITS shifts complete
frame_abort  out  1  one-cycle pulse when SS deasserts mid-byte
digit_overrun  out  1  sticky flag: a digit was overwritten before it was sent

Behaviour:
- Reset (asynchronous, rst=1):
  - All outputs 0, except tx_byte=IDLE_BYTE.
  - FSM goes to SELECT; bit_cnt=0; pending flags, cost_wait, latched values and the synchronizer flops are all cleared.
  - Synchronizer flops reset to sck=0, ss_n=1.
- Synchronizer: sck and ss_n each pass through SYNC_STAGES flops.
  - shift_en = falling edge of synced sck AND synced ss_n==0 AND state==ARMED.
- Pending bookkeeping (registered):
  - network_done: digit_pending<=1 and digit_q<=detected_digit. If digit_pending was already 1 and is not being cleared in that cycle, digit_overrun<=1.
  - cmd_valid with cmd==CMD_COST and cost_wait==0 and cost_pending==0: cost_req=1 for that cycle, cost_wait<=1. Any other command, or a duplicate request, is ignored.
  - cost_ready with cost_wait==1: cost_pending<=1, cost_q<=cost_output, cost_wait<=0. cost_ready with cost_wait==0 is ignored.
  - A set and a clear of the same pending flag in one cycle: the set wins.
- Source selection, in priority order:
  - cost_pending: tx_byte=cost_q
  - else digit_pending: tx_byte={4'h0,digit_q}
  - else: tx_byte=IDLE_BYTE
- FSM states:
  - SELECT: latch src from the priority rule; next LOAD.
  - LOAD: load_en=1, tx_byte per src, bit_cnt<=0; next ARMED.
  - ARMED:
    - Each shift_en increments bit_cnt.
    - On the shift_en that makes bit_cnt==BYTE_BITS: next DONE.
    - If bit_cnt==0, synced ss_n==1, src==IDLE and any pending flag is 1: next SELECT (preload a real byte before the frame starts).
    - If synced ss_n rises while bit_cnt is 1..BYTE_BITS-1: frame_abort=1, bit_cnt<=0, pending flags untouched, next SELECT. The same byte is retransmitted.
  - DONE: byte_sent=1; clear the pending flag for src (none if src is IDLE); next SELECT.
- Latency:
  - network_done in cycle N while the FSM is ARMED with src==IDLE, bit_cnt=0, ss_n high: SELECT in N+2, load_en=1 in N+3.
  - Each byte costs 3 clk cycles of overhead after its last shift (DONE, SELECT, LOAD). The SPI master must leave at least (SYNC_STAGES+3) clk cycles between bytes; violating this is a master error and is not detected.
- SS held low across several bytes: consecutive bytes are sent back-to-back, each reselected by priority.

Decomposition:
- Package spi_tx_pkg holds:
  - state_t enum {SELECT, LOAD, ARMED, DONE}
  - tx_src_t enum {SRC_IDLE, SRC_DIGIT, SRC_COST}
  - constants CMD_COST and IDLE_BYTE defaults
- Sub-module spi_sync_edge (parameter SYNC_STAGES): one instance per pad input. Outputs the synced level plus rise/fall pulses. Instantiated for sck and ss_n.

Test Plan:
- Reset with nothing pending, then one 8-SCK frame with ss_n low -> load_en once, tx_byte=8'hFF, 8 shift_en pulses, then byte_sent; no cost_req.
- network_done with digit 4'd7 while idle and ss_n high -> load_en in N+3 with tx_byte=8'h07; after the frame, byte_sent and digit_pending=0.
- cmd 8'h01 -> cost_req pulse; cost_ready with 8'hA5 -> preload 8'hA5. Digit 4'd3 arriving in the same frame -> 8'hA5 sent first, then 8'h03 in the next frame.
- ss_n raised after 4 SCK falling edges while sending 8'h03 -> frame_abort pulse, no byte_sent, 8'h03 reloaded; a full retry frame then gives byte_sent.
- Two network_done strobes (digits 5 then 9) with no frame between -> digit_overrun=1, transmitted byte 8'h09.
- cost_ready with no request outstanding, plus a duplicate 8'h01 while cost_wait=1 -> both ignored, only one cost_req; rst asserted mid-frame -> all outputs reset values, tx_byte=8'hFF.

Source files
------------

// File: rtl/spi_tx_pkg.sv
// Shared types and defaults for the SPI transmit scheduler: FSM states,
// transmit source encoding and the priority pick between pending results.
package spi_tx_pkg;

  typedef enum logic [1:0] {
    SELECT = 2'd0,
    LOAD   = 2'd1,
    ARMED  = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SRC_IDLE  = 2'd0,
    SRC_DIGIT = 2'd1,
    SRC_COST  = 2'd2
  } tx_src_t;

  localparam logic [7:0] CMD_COST_DEF  = 8'h01;
  localparam logic [7:0] IDLE_BYTE_DEF = 8'hFF;

  // Cost results outrank digits; with nothing pending the filler is sent.
  function automatic tx_src_t pick_src(input logic cost_pending, input logic digit_pending);
    tx_src_t s;
    if (cost_pending) begin
      s = SRC_COST;
    end else if (digit_pending) begin
      s = SRC_DIGIT;
    end else begin
      s = SRC_IDLE;
    end
    return s;
  endfunction

endpackage

// File: rtl/spi_tx_scheduler_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pad input, with rise/fall
// pulses derived from the synchronized level.
module spi_sync_edge
  import spi_tx_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Synchronizer chain plus one history flop; the history flop resets to the
  // same idle level so no spurious edge follows reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{RESET_VAL}};
      prev_r <= RESET_VAL;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign level = sync_r[SYNC_STAGES-1];
  assign rise  = level & ~prev_r;
  assign fall  = ~level & prev_r;

endmodule

// File: rtl/spi_tx_scheduler.sv
// Sequences the SPI output shift register: picks cost/digit/filler bytes,
// frames each byte from the synchronized SCK/SS and tracks pending results.
module spi_tx_scheduler
  import spi_tx_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         BYTE_BITS   = 8,
  parameter logic [7:0] IDLE_BYTE   = IDLE_BYTE_DEF,
  parameter logic [7:0] CMD_COST    = CMD_COST_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       ss_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd,
  input  logic       network_done,
  input  logic [3:0] detected_digit,
  input  logic       cost_ready,
  input  logic [7:0] cost_output,
  output logic       cost_req,
  output logic       load_en,
  output logic [7:0] tx_byte,
  output logic       shift_en,
  output logic       byte_sent,
  output logic       frame_abort,
  output logic       digit_overrun
);

  localparam int               CNT_W    = $clog2(BYTE_BITS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTE_BITS);

  logic sck_level, sck_rise, sck_fall;
  logic ss_level, ss_rise, ss_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .din(sck), .level(sck_level), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst(rst), .din(ss_n), .level(ss_level), .rise(ss_rise), .fall(ss_fall)
  );

  // Only falling SCK and rising SS edges matter for this protocol.
  logic unused_edges;
  assign unused_edges = &{1'b0, sck_level, sck_rise, ss_fall};

  state_t           state_r, state_next_s;
  tx_src_t          src_r, src_next_s;
  logic [CNT_W-1:0] bit_cnt_r, bit_cnt_next_s;
  logic [7:0]       tx_byte_r, tx_byte_next_s;
  logic             load_en_s, shift_en_s, byte_sent_s, frame_abort_s;

  logic       digit_pending_r, cost_pending_r, cost_wait_r, overrun_r;
  logic [3:0] digit_q_r;
  logic [7:0] cost_q_r;
  logic       cost_req_s, clr_digit_s, clr_cost_s, cost_take_s;

  function automatic logic [7:0] src_byte(input tx_src_t s, input logic [7:0] c,
                                          input logic [3:0] d);
    logic [7:0] b;
    case (s)
      SRC_COST:  b = c;
      SRC_DIGIT: b = {4'h0, d};
      default:   b = IDLE_BYTE;
    endcase
    return b;
  endfunction

  // FSM state and transmit datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= SELECT;
      src_r     <= SRC_IDLE;
      bit_cnt_r <= {CNT_W{1'b0}};
      tx_byte_r <= IDLE_BYTE;
    end else begin
      state_r   <= state_next_s;
      src_r     <= src_next_s;
      bit_cnt_r <= bit_cnt_next_s;
      tx_byte_r <= tx_byte_next_s;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_next_s   = state_r;
    src_next_s     = src_r;
    bit_cnt_next_s = bit_cnt_r;
    tx_byte_next_s = tx_byte_r;
    load_en_s      = 1'b0;
    shift_en_s     = 1'b0;
    byte_sent_s    = 1'b0;
    frame_abort_s  = 1'b0;
    case (state_r)
      SELECT: begin
        src_next_s     = pick_src(cost_pending_r, digit_pending_r);
        tx_byte_next_s = src_byte(src_next_s, cost_q_r, digit_q_r);
        state_next_s   = LOAD;
      end
      LOAD: begin
        load_en_s      = 1'b1;
        bit_cnt_next_s = {CNT_W{1'b0}};
        state_next_s   = ARMED;
      end
      ARMED: begin
        shift_en_s = sck_fall & ~ss_level;
        if (shift_en_s) begin
          bit_cnt_next_s = bit_cnt_r + CNT_W'(1);
          if ((bit_cnt_r + CNT_W'(1)) == LAST_CNT) begin
            state_next_s = DONE;
          end else begin
            state_next_s = ARMED;
          end
        end else if (ss_rise && (bit_cnt_r != {CNT_W{1'b0}})) begin
          // Master gave up mid-byte: keep pending results and resend.
          frame_abort_s  = 1'b1;
          bit_cnt_next_s = {CNT_W{1'b0}};
          state_next_s   = SELECT;
        end else if ((bit_cnt_r == {CNT_W{1'b0}}) && ss_level && (src_r == SRC_IDLE) &&
                     (cost_pending_r || digit_pending_r)) begin
          state_next_s = SELECT;
        end else begin
          state_next_s = ARMED;
        end
      end
      DONE: begin
        byte_sent_s  = 1'b1;
        state_next_s = SELECT;
      end
      default: begin
        state_next_s = SELECT;
      end
    endcase
  end

  assign clr_digit_s = (state_r == DONE) && (src_r == SRC_DIGIT);
  assign clr_cost_s  = (state_r == DONE) && (src_r == SRC_COST);
  assign cost_req_s  = cmd_valid && (cmd == CMD_COST) && !cost_wait_r && !cost_pending_r;
  assign cost_take_s = cost_ready && cost_wait_r;

  // Pending result bookkeeping; a set always beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_pending_r <= 1'b0;
      digit_q_r       <= 4'h0;
      overrun_r       <= 1'b0;
      cost_wait_r     <= 1'b0;
      cost_pending_r  <= 1'b0;
      cost_q_r        <= 8'h00;
    end else begin
      if (network_done) begin
        digit_pending_r <= 1'b1;
        digit_q_r       <= detected_digit;
        if (digit_pending_r && !clr_digit_s) begin
          overrun_r <= 1'b1;
        end
      end else if (clr_digit_s) begin
        digit_pending_r <= 1'b0;
      end

      if (cost_req_s) begin
        cost_wait_r <= 1'b1;
      end else if (cost_take_s) begin
        cost_wait_r <= 1'b0;
      end

      if (cost_take_s) begin
        cost_pending_r <= 1'b1;
        cost_q_r       <= cost_output;
      end else if (clr_cost_s) begin
        cost_pending_r <= 1'b0;
      end
    end
  end

  assign cost_req      = cost_req_s;
  assign load_en       = load_en_s;
  assign tx_byte       = tx_byte_r;
  assign shift_en      = shift_en_s;
  assign byte_sent     = byte_sent_s;
  assign frame_abort   = frame_abort_s;
  assign digit_overrun = overrun_r;

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Randomized scoreboard bench for spi_tx_scheduler: a result-level model
// predicts every transmitted/aborted byte; a monitor checks DUT frame events.
module tb_spi_tx_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       ss_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd = 8'h00;
  logic       network_done = 1'b0;
  logic [3:0] detected_digit = 4'h0;
  logic       cost_ready = 1'b0;
  logic [7:0] cost_output = 8'h00;
  logic       cost_req, load_en, shift_en, byte_sent, frame_abort, digit_overrun;
  logic [7:0] tx_byte;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_tx_scheduler dut (
    .clk(clk), .rst(rst), .sck(sck), .ss_n(ss_n),
    .cmd_valid(cmd_valid), .cmd(cmd),
    .network_done(network_done), .detected_digit(detected_digit),
    .cost_ready(cost_ready), .cost_output(cost_output),
    .cost_req(cost_req), .load_en(load_en), .tx_byte(tx_byte),
    .shift_en(shift_en), .byte_sent(byte_sent), .frame_abort(frame_abort),
    .digit_overrun(digit_overrun)
  );

  typedef struct {
    bit         abort;
    logic [7:0] byte_v;
    int         nsh;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: what results are outstanding and which byte sits in the
  // output register (0 = filler, 1 = digit, 2 = cost).
  bit         m_dpend, m_cpend, m_cwait, m_ovr;
  logic [3:0] m_digit;
  logic [7:0] m_cost, m_loaded;
  int         m_src;
  int         m_reqs = 0;
  int         seen_reqs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function void m_pick();
    if (m_cpend) begin
      m_src = 2; m_loaded = m_cost;
    end else if (m_dpend) begin
      m_src = 1; m_loaded = {4'h0, m_digit};
    end else begin
      m_src = 0; m_loaded = 8'hFF;
    end
  endfunction

  function void m_reset();
    m_dpend = 0; m_cpend = 0; m_cwait = 0; m_ovr = 0;
    m_digit = 4'h0; m_cost = 8'h00;
    m_pick();
  endfunction

  // An idle filler is swapped for a real result while the bus is quiet.
  function void m_refresh();
    if (m_src == 0 && (m_cpend || m_dpend)) m_pick();
  endfunction

  function void m_digit_evt(input logic [3:0] d);
    if (m_dpend) m_ovr = 1;
    m_dpend = 1;
    m_digit = d;
  endfunction

  function void m_cmd_evt(input logic [7:0] c);
    if (c == 8'h01 && !m_cwait && !m_cpend) begin
      m_reqs++;
      m_cwait = 1;
    end
  endfunction

  function void m_cost_evt(input logic [7:0] v);
    if (m_cwait) begin
      m_cpend = 1; m_cost = v; m_cwait = 0;
    end
  endfunction

  // Monitor: tracks what the DUT loaded and shifted, pops expectations on
  // every completed or aborted byte.
  logic [7:0] last_load = 8'h00;
  int         shifts = 0;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      if (load_en) begin
        last_load = tx_byte;
        shifts = 0;
      end
      if (shift_en) shifts++;
      if (cost_req) seen_reqs++;
      if (byte_sent || frame_abort) begin
        if (exp_q.size() == 0) begin
          check("spurious_frame_event", {byte_sent, frame_abort}, 2'b00);
        end else begin
          mon_e = exp_q.pop_front();
          check("abort_flag", frame_abort, mon_e.abort);
          check("sent_flag", byte_sent, !mon_e.abort);
          check("frame_byte", last_load, mon_e.byte_v);
          check("shift_count", shifts, mon_e.nsh);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_digit(input logic [3:0] d);
    @(posedge clk); #1;
    network_done = 1'b1; detected_digit = d;
    m_digit_evt(d);
    @(posedge clk); #1;
    network_done = 1'b0;
  endtask

  task automatic pulse_cmd(input logic [7:0] c);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd = c;
    m_cmd_evt(c);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_cost(input logic [7:0] v);
    @(posedge clk); #1;
    cost_ready = 1'b1; cost_output = v;
    m_cost_evt(v);
    @(posedge clk); #1;
    cost_ready = 1'b0;
  endtask

  task automatic sck_cycle();
    sck = 1'b1;
    idle(4);
    sck = 1'b0;
    idle(4);
  endtask

  // One SS-low frame with nfalls SCK falling edges; fewer than 8 aborts.
  task automatic run_frame(input int nfalls, input bit mid, input logic [3:0] md);
    exp_t e;
    e.abort = (nfalls < 8);
    e.byte_v = m_loaded;
    e.nsh = nfalls;
    exp_q.push_back(e);
    @(posedge clk); #1;
    ss_n = 1'b0;
    idle(4);
    for (int i = 0; i < nfalls; i++) begin
      sck_cycle();
      if (mid && i == 3) pulse_digit(md);
    end
    idle(8);
    ss_n = 1'b1;
    idle(10);
    if (nfalls >= 8) begin
      if (m_src == 1) m_dpend = 0;
      else if (m_src == 2) m_cpend = 0;
    end
    m_pick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_byte"}, tx_byte, 8'hFF);
    check({tag, "_strobes"}, {load_en, shift_en, byte_sent, frame_abort, cost_req}, 5'b0);
    check({tag, "_overrun"}, digit_overrun, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int reqs0;
    logic [7:0] lat_byte;

    m_reset();
    idle(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(10);

    // Nothing pending: filler byte.
    run_frame(8, 1'b0, 4'h0);
    check("no_cost_req", seen_reqs, 0);

    // Digit preload latency: load_en three cycles after the strobe cycle.
    lat = -1;
    lat_byte = 8'h00;
    @(posedge clk); #1;
    network_done = 1'b1; detected_digit = 4'd7;
    m_digit_evt(4'd7);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (load_en) begin
        lat = i; lat_byte = tx_byte;
        break;
      end
      @(posedge clk); #1;
      network_done = 1'b0;
    end
    network_done = 1'b0;
    check("preload_latency", lat, 3);
    check("preload_byte", lat_byte, 8'h07);
    m_refresh();
    idle(10);
    run_frame(8, 1'b0, 4'h0);

    // Cost request path; a digit arriving mid-frame goes out next.
    pulse_cmd(8'h01);
    idle(5);
    check("cost_req_once", seen_reqs, 1);
    pulse_cost(8'hA5);
    idle(10); m_refresh();
    run_frame(8, 1'b1, 4'd3);
    run_frame(4, 1'b0, 4'h0);
    run_frame(8, 1'b0, 4'h0);

    // Back-to-back digits: the later one wins and overrun is flagged.
    @(posedge clk); #1;
    network_done = 1'b1; detected_digit = 4'd5; m_digit_evt(4'd5);
    @(posedge clk); #1;
    detected_digit = 4'd9; m_digit_evt(4'd9);
    @(posedge clk); #1;
    network_done = 1'b0;
    idle(10); m_refresh();
    check("overrun_set", digit_overrun, 1'b1);
    run_frame(8, 1'b0, 4'h0);

    // Stray cost_ready and duplicate command are ignored.
    reqs0 = seen_reqs;
    pulse_cost(8'h55);
    idle(5);
    pulse_cmd(8'h01);
    idle(3);
    pulse_cmd(8'h01);
    idle(3);
    pulse_cost(8'h3C);
    idle(10); m_refresh();
    check("single_cost_req", seen_reqs - reqs0, 1);

    // Reset in the middle of a frame carrying 8'h3C.
    ss_n = 1'b0;
    idle(4);
    sck_cycle();
    sck_cycle();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midframe_reset");
    sck = 1'b0; ss_n = 1'b1;
    idle(3);
    rst = 1'b0;
    m_reset();
    exp_q.delete();
    idle(10);
    run_frame(8, 1'b0, 4'h0);

    // Randomized mix of events and frames.
    for (int it = 0; it < 60; it++) begin
      int act;
      act = $urandom_range(0, 5);
      case (act)
        0: pulse_digit(4'($urandom_range(0, 15)));
        1: pulse_cmd(($urandom_range(0, 1) == 0) ? 8'h01 : 8'($urandom_range(0, 255)));
        2: pulse_cost(8'($urandom_range(0, 255)));
        3: run_frame(8, 1'b0, 4'h0);
        4: run_frame($urandom_range(1, 7), 1'b0, 4'h0);
        default: run_frame(8, 1'b1, 4'($urandom_range(0, 15)));
      endcase
      idle(8);
      m_refresh();
      check("overrun_flag", digit_overrun, m_ovr);
    end

    idle(20);
    check("queue_drained", exp_q.size(), 0);
    check("cost_req_total", seen_reqs, m_reqs);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
